// File: rtl/rf_alu_seq_pkg.sv
// rf_alu_seq_pkg: shared types and constants for the word-serial ALU sequencer.
//   op_e     : request opcode (ADD/SUB/AND/XOR), matches the 2-bit req_op encoding
//   state_e  : sequencer FSM states
//   ctrl_t   : per-digit ALU control bundle
//   DIGIT_W  : width of one ALU digit
//   ALU_LAT_DEFAULT : default input-to-output latency of the ALU slice
package rf_alu_seq_pkg;

   localparam int DIGIT_W         = 2;
   localparam int ALU_LAT_DEFAULT = 7;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_AND = 2'd2,
      OP_XOR = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef struct packed {
      logic cmpl_y;
      logic op_and;
      logic op_xor;
      logic op_arith;
   } ctrl_t;

   function automatic logic op_is_arith(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // ALU control lines for one issued digit of the given op.
   function automatic ctrl_t op_ctrl(input op_e op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_ADD: c.op_arith = 1'b1;
         OP_SUB: begin
            c.op_arith = 1'b1;
            c.cmpl_y   = 1'b1;
         end
         OP_AND: c.op_and = 1'b1;
         OP_XOR: c.op_xor = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rf_alu_seq_if.sv
// rf_alu_seq_if: request/response bus between the instruction datapath and the
// sequencer.
//   req_valid/req_ready   : request handshake, carries req_op, req_a, req_b, req_cin
//   resp_valid/resp_ready : response handshake, carries resp_z, resp_cout, resp_ovf
//   master modport : the datapath side issuing requests
//   slave modport  : the sequencer side serving them
interface rf_alu_seq_if #(
   parameter int WORD_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [WORD_W-1:0] req_a;
   logic [WORD_W-1:0] req_b;
   logic              req_cin;
   logic              resp_valid;
   logic              resp_ready;
   logic [WORD_W-1:0] resp_z;
   logic              resp_cout;
   logic              resp_ovf;

   modport master (
      output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
      input  req_ready, resp_valid, resp_z, resp_cout, resp_ovf
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
      output req_ready, resp_valid, resp_z, resp_cout, resp_ovf
   );
endinterface

// File: rtl/rf_alu_seq_tagpipe.sv
// rf_alu_seq_tagpipe: LAT-deep shift register of {valid, digit index} that
// travels alongside the ALU pipeline, so a returning digit is recognised and
// placed without trusting the ALU outputs themselves.
//   clk, rst_n        : clock, asynchronous active-low clear
//   in_valid, in_idx  : tag of the digit issued this cycle
//   out_valid, out_idx: tag of the digit whose result is on the ALU outputs now
module rf_alu_seq_tagpipe #(
   parameter int LAT   = 7,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   logic [LAT-1:0]   valid_reg;
   logic [IDX_W-1:0] idx_reg [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         for (int i = 0; i < LAT; i++) begin
            idx_reg[i] <= '0;
         end
      end else begin
         valid_reg[0] <= in_valid;
         idx_reg[0]   <= in_idx;
         for (int i = 1; i < LAT; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            idx_reg[i]   <= idx_reg[i-1];
         end
      end
   end

   assign out_valid = valid_reg[LAT-1];
   assign out_idx   = idx_reg[LAT-1];

endmodule

// File: rtl/rf_alu_seq.sv
// rf_alu_seq: word-serial sequencer in front of a 2-bit pipelined RSFQ ALU slice.
// Splits a WORD_W-bit ADD/SUB/AND/XOR into WORD_W/2 digits (LSD first), chains
// carries for arithmetic ops, and reassembles the returned digits into a word.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/response bus (slave side)
//   alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
//   alu_op_and, alu_op_xor, alu_op_arith : digit and controls to the ALU slice
//   alu_zout, alu_carry_out, alu_overflow: results returning ALU_LAT cycles later
module rf_alu_seq
   import rf_alu_seq_pkg::*;
#(
   parameter int WORD_W  = 8,
   parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   rf_alu_seq_if.slave        bus,
   output logic [DIGIT_W-1:0] alu_xin,
   output logic [DIGIT_W-1:0] alu_yin,
   output logic               alu_carry_in,
   output logic               alu_end_bar,
   output logic               alu_cmpl_x,
   output logic               alu_cmpl_y,
   output logic               alu_op_and,
   output logic               alu_op_xor,
   output logic               alu_op_arith,
   input  logic [DIGIT_W-1:0] alu_zout,
   input  logic               alu_carry_out,
   input  logic               alu_overflow
);

   localparam int N     = WORD_W / DIGIT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_e             state_reg;
   op_e                op_reg;
   logic [WORD_W-1:0]  a_reg;
   logic [WORD_W-1:0]  b_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic [DIGIT_W-1:0] xin_reg;
   logic [DIGIT_W-1:0] yin_reg;
   logic               carry_in_reg;
   logic               issue_reg;
   ctrl_t              ctrl_reg;
   logic               req_ready_reg;
   logic               resp_valid_reg;
   logic [WORD_W-1:0]  resp_z_reg;
   logic               resp_cout_reg;
   logic               resp_ovf_reg;

   logic               tag_valid;
   logic [IDX_W-1:0]   tag_idx;
   logic [IDX_W-1:0]   next_idx;

   // Tag follows the digit on the ALU inputs this cycle.
   rf_alu_seq_tagpipe #(
      .LAT   (ALU_LAT),
      .IDX_W (IDX_W)
   ) u_tagpipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (issue_reg),
      .in_idx    (idx_reg),
      .out_valid (tag_valid),
      .out_idx   (tag_idx)
   );

   // Arithmetic ops resume from the returning digit; logic ops stream from
   // the digit currently being issued.
   always_comb begin
      next_idx = idx_reg + 1'b1;
      if (state_reg == ST_WAIT) begin
         next_idx = tag_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         op_reg         <= OP_ADD;
         a_reg          <= '0;
         b_reg          <= '0;
         idx_reg        <= '0;
         xin_reg        <= '0;
         yin_reg        <= '0;
         carry_in_reg   <= 1'b0;
         issue_reg      <= 1'b0;
         ctrl_reg       <= '0;
         req_ready_reg  <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_z_reg     <= '0;
         resp_cout_reg  <= 1'b0;
         resp_ovf_reg   <= 1'b0;
      end else begin
         // The slice reads an absent pulse as 0, so every non-issue cycle
         // drives all ALU lines low.
         issue_reg    <= 1'b0;
         xin_reg      <= '0;
         yin_reg      <= '0;
         carry_in_reg <= 1'b0;
         ctrl_reg     <= '0;

         if (tag_valid) begin
            resp_z_reg[DIGIT_W*tag_idx +: DIGIT_W] <= alu_zout;
         end

         case (state_reg)
            ST_IDLE: begin
               req_ready_reg <= 1'b1;
               if (bus.req_valid && req_ready_reg) begin
                  req_ready_reg <= 1'b0;
                  op_reg        <= op_e'(bus.req_op);
                  a_reg         <= bus.req_a;
                  b_reg         <= bus.req_b;
                  idx_reg       <= '0;
                  issue_reg     <= 1'b1;
                  xin_reg       <= bus.req_a[DIGIT_W-1:0];
                  yin_reg       <= bus.req_b[DIGIT_W-1:0];
                  carry_in_reg  <= op_is_arith(op_e'(bus.req_op)) & bus.req_cin;
                  ctrl_reg      <= op_ctrl(op_e'(bus.req_op));
                  state_reg     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (!op_is_arith(op_reg) && (idx_reg != LAST_IDX)) begin
                  idx_reg   <= next_idx;
                  issue_reg <= 1'b1;
                  xin_reg   <= a_reg[DIGIT_W*next_idx +: DIGIT_W];
                  yin_reg   <= b_reg[DIGIT_W*next_idx +: DIGIT_W];
                  ctrl_reg  <= op_ctrl(op_reg);
               end else begin
                  state_reg <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (tag_valid) begin
                  if (tag_idx == LAST_IDX) begin
                     resp_valid_reg <= 1'b1;
                     resp_cout_reg  <= op_is_arith(op_reg) & alu_carry_out;
                     resp_ovf_reg   <= op_is_arith(op_reg) & alu_overflow;
                     state_reg      <= ST_RESP;
                  end else if (op_is_arith(op_reg)) begin
                     // Carry of digit k goes straight into digit k+1.
                     idx_reg      <= next_idx;
                     issue_reg    <= 1'b1;
                     xin_reg      <= a_reg[DIGIT_W*next_idx +: DIGIT_W];
                     yin_reg      <= b_reg[DIGIT_W*next_idx +: DIGIT_W];
                     carry_in_reg <= alu_carry_out;
                     ctrl_reg     <= op_ctrl(op_reg);
                     state_reg    <= ST_ISSUE;
                  end
               end
            end

            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= ST_IDLE;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_z     = resp_z_reg;
   assign bus.resp_cout  = resp_cout_reg;
   assign bus.resp_ovf   = resp_ovf_reg;

   assign alu_xin      = xin_reg;
   assign alu_yin      = yin_reg;
   assign alu_carry_in = carry_in_reg;
   assign alu_end_bar  = issue_reg;
   assign alu_cmpl_x   = 1'b0;
   assign alu_cmpl_y   = ctrl_reg.cmpl_y;
   assign alu_op_and   = ctrl_reg.op_and;
   assign alu_op_xor   = ctrl_reg.op_xor;
   assign alu_op_arith = ctrl_reg.op_arith;

endmodule
